// File: rtl/switch_debounce_pkg.sv
// rtl/switch_debounce_pkg.sv - shared defaults and helpers for the switch debouncer
package switch_debounce_pkg;

  // System clock frequency the default tick period is derived from.
  localparam int SysClkFreq = 40_000_000;

  // 8 user DIP + 5 navigation + 3 software-select switches.
  localparam int SwDebounceWidth = 16;

  // One sample tick per millisecond of system clock.
  localparam int SwDebounceTickCycles = SysClkFreq / 1000;

  // Consecutive mismatching ticks required before a new level is accepted.
  localparam int SwDebounceStableTicks = 5;

  // Counter width able to hold 0..stable_ticks.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// rtl/switch_debounce_if.sv - debounced level and edge event bundle
interface switch_debounce_if #(
  parameter int Width = 16
);

  logic [Width-1:0] sw_o;
  logic [Width-1:0] rise_o;
  logic [Width-1:0] fall_o;
  logic             changed_o;

  // Debouncer drives the bundle.
  modport master (
    output sw_o,
    output rise_o,
    output fall_o,
    output changed_o
  );

  // Consumer samples the bundle every cycle.
  modport slave (
    input sw_o,
    input rise_o,
    input fall_o,
    input changed_o
  );

endinterface

// File: rtl/switch_debounce_bit.sv
// rtl/switch_debounce_bit.sv - per-bit stability filter and edge detector
module switch_debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int   StableTicks = 5,
  parameter logic ResetVal    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  input  logic tick_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_o
);

  localparam int            CntW    = cnt_width(StableTicks);
  localparam logic [CntW-1:0] CntLast = CntW'(StableTicks - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lvl_q, lvl_d;
  logic            prev_q;
  logic            accept;

  // Matching input clears qualification at once; mismatches only advance on ticks.
  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    accept = 1'b0;
    if (sync_i == lvl_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CntLast) begin
        lvl_d  = sync_i;
        cnt_d  = '0;
        accept = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Accepted level, its one-cycle-delayed copy for edge detection, and the counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      lvl_q  <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
    end
  end

  assign sw_o     = lvl_q;
  assign rise_o   = lvl_q & ~prev_q;
  assign fall_o   = ~lvl_q & prev_q;
  // Tells the parent that the level flips on the next edge.
  assign accept_o = accept;

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - synchronise and debounce mechanical switch inputs
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int               Width       = SwDebounceWidth,
  parameter int               TickCycles  = SwDebounceTickCycles,
  parameter int               StableTicks = SwDebounceStableTicks,
  parameter logic [Width-1:0] ResetVal    = '0
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_ni,
  input  logic [Width-1:0]  sw_i,
  switch_debounce_if.master ev
);

  localparam int             TickW    = $clog2(TickCycles);
  localparam logic [TickW-1:0] TickLast = TickW'(TickCycles - 1);

  logic [Width-1:0] sync1_q, sync2_q;
  logic [TickW-1:0] pre_q, pre_d;
  logic             tick;
  logic [Width-1:0] sw_w, rise_w, fall_w, accept_w;
  logic             changed_q;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync1_q <= ResetVal;
      sync2_q <= ResetVal;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  // Free-running sample prescaler shared by every bit.
  always_comb begin
    tick  = (pre_q == TickLast);
    pre_d = tick ? '0 : pre_q + TickW'(1);
  end

  // Prescaler count register.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < Width; g++) begin : g_bit
    switch_debounce_bit #(
      .StableTicks (StableTicks),
      .ResetVal    (ResetVal[g])
    ) u_bit (
      .clk_i    (clk_sys_i),
      .rst_ni   (rst_sys_ni),
      .sync_i   (sync2_q[g]),
      .tick_i   (tick),
      .sw_o     (sw_w[g]),
      .rise_o   (rise_w[g]),
      .fall_o   (fall_w[g]),
      .accept_o (accept_w[g])
    );
  end

  // Any acceptance this cycle means some bit has an edge in the next cycle.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |accept_w;
    end
  end

  assign ev.sw_o      = sw_w;
  assign ev.rise_o    = rise_w;
  assign ev.fall_o    = fall_w;
  assign ev.changed_o = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - directed scoreboard bench for switch_debounce
module tb_switch_debounce;

  typedef struct {
    logic [15:0] sw;
    logic [15:0] rise;
    logic [15:0] fall;
    logic        changed;
    int          cyc;
  } obs_t;

  typedef struct {
    logic [15:0] sw;
    logic [15:0] rise;
    logic [15:0] fall;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] sw_i = 16'h0000;
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  obs_t        obs_q[$];
  exp_t        exp_q[$];

  switch_debounce_if #(.Width(16)) ev ();

  switch_debounce #(
    .Width       (16),
    .TickCycles  (4),
    .StableTicks (3),
    .ResetVal    (16'h0000)
  ) dut (
    .clk_sys_i  (clk),
    .rst_sys_ni (rst_n),
    .sw_i       (sw_i),
    .ev         (ev)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle that shows any edge activity.
  always @(negedge clk) begin
    if (rst_n && (ev.changed_o || ev.rise_o != 16'h0 || ev.fall_o != 16'h0))
      obs_q.push_back('{ev.sw_o, ev.rise_o, ev.fall_o, ev.changed_o, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] v, input logic [15:0] es,
                      input logic [15:0] er, input logic [15:0] ef);
    sw_i = v;
    exp_q.push_back('{es, er, ef, cyc});
  endtask

  task automatic wait_event(input string tag);
    int   k;
    int   lat;
    obs_t o;
    exp_t e;
    k = 0;
    while (obs_q.size() == 0 && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    e = exp_q.pop_front();
    chk({tag, "_seen"}, {31'd0, obs_q.size() != 0}, 32'd1);
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      lat = o.cyc - e.t0;
      chk({tag, "_sw"}, {16'h0, o.sw}, {16'h0, e.sw});
      chk({tag, "_rise"}, {16'h0, o.rise}, {16'h0, e.rise});
      chk({tag, "_fall"}, {16'h0, o.fall}, {16'h0, e.fall});
      chk({tag, "_changed"}, {31'd0, o.changed}, 32'd1);
      chk({tag, "_latency_11_15"}, {31'd0, (lat >= 11 && lat <= 15)}, 32'd1);
    end
  endtask

  task automatic quiet(input string tag, input int n, input logic [15:0] exp_sw);
    repeat (n) @(negedge clk);
    #1;
    chk({tag, "_no_extra_events"}, obs_q.size(), 32'd0);
    chk({tag, "_level"}, {16'h0, ev.sw_o}, {16'h0, exp_sw});
    obs_q.delete();
  endtask

  initial begin
    // Reset with all switches on
    sw_i = 16'hFFFF;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_sw", {16'h0, ev.sw_o}, 32'h0);
    chk("reset_rise", {16'h0, ev.rise_o}, 32'h0);
    chk("reset_fall", {16'h0, ev.fall_o}, 32'h0);
    chk("reset_changed", {31'd0, ev.changed_o}, 32'd0);
    rst_n = 1'b1;
    step(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
    wait_event("reset_release");
    quiet("reset_release", 20, 16'hFFFF);

    // All off, then a clean step on bit 3
    step(16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    wait_event("all_fall");
    quiet("all_fall", 20, 16'h0000);
    step(16'h0008, 16'h0008, 16'h0008, 16'h0000);
    wait_event("clean_step");
    quiet("clean_step", 20, 16'h0008);

    // Short glitches on bit 0 never pass
    for (int i = 0; i < 4; i++) begin
      sw_i = 16'h0009;
      repeat (7) @(negedge clk);
      sw_i = 16'h0008;
      repeat (13) @(negedge clk);
    end
    quiet("glitch", 20, 16'h0008);

    // Bounce on bit 5, then hold high
    for (int i = 0; i < 10; i++) begin
      sw_i = (i % 2 == 0) ? 16'h0028 : 16'h0008;
      repeat (3) @(negedge clk);
    end
    step(16'h0028, 16'h0028, 16'h0020, 16'h0000);
    wait_event("bounce");
    quiet("bounce", 20, 16'h0028);

    // Move to 00F0, then simultaneous rise/fall to 0F00
    step(16'h00F0, 16'h00F0, 16'h00D0, 16'h0008);
    wait_event("to_00f0");
    quiet("to_00f0", 20, 16'h00F0);
    step(16'h0F00, 16'h0F00, 16'h0F00, 16'h00F0);
    wait_event("simultaneous");
    quiet("simultaneous", 20, 16'h0F00);
    step(16'h0000, 16'h0000, 16'h0000, 16'h0F00);
    wait_event("clear");
    quiet("clear", 20, 16'h0000);

    // Reset in the middle of qualifying bit 1
    sw_i = 16'h0002;
    repeat (8) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_sw", {16'h0, ev.sw_o}, 32'h0);
    chk("midreset_rise", {16'h0, ev.rise_o}, 32'h0);
    chk("midreset_changed", {31'd0, ev.changed_o}, 32'd0);
    chk("midreset_no_early_event", obs_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(16'h0002, 16'h0002, 16'h0002, 16'h0000);
    wait_event("midreset_release");
    quiet("midreset_release", 20, 16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Synchronises and debounces the board's switch inputs (user DIP switches, navigation joystick and software-select switches) before they reach the GPIO input word of `sonata_system`. It sits directly upstream of the `gp_i` port. The already-inverted, active-high switch levels go in, and stable levels plus single-cycle edge events come out. The block runs entirely in the system clock domain and removes contact bounce and metastability from asynchronous mechanical inputs.

## Interface
Parameters:
- `Width`, 16: number of switch bits (8 user + 5 nav + 3 sel).
- `TickCycles`, 40_000: system clocks per sample tick (1 ms at 40 MHz). Must be ≥ 2.
- `StableTicks`, 5: consecutive mismatching ticks needed to accept a new level. Must be ≥ 1.
- `ResetVal`, `'0`: reset value of the synchroniser and of `sw_o`, per bit.

Ports:
- `clk_sys_i`, in, 1: system clock.
- `rst_sys_ni`, in, 1: reset. Asynchronous, active-low.
- `sw_i`, in, `Width`: raw switch levels. Asynchronous to `clk_sys_i`.
- `sw_o`, out, `Width`: debounced levels, registered.
- `rise_o`, out, `Width`: one-cycle pulse when the matching `sw_o` bit goes 0→1.
- `fall_o`, out, `Width`: one-cycle pulse when the matching `sw_o` bit goes 1→0.
- `changed_o`, out, 1: OR of all `rise_o` and `fall_o` bits, registered in the same cycle as them.

## Operation
Synchroniser:
- Each `sw_i` bit passes through a 2-flop synchroniser, giving `sync`.
- The synchroniser flops reset to `ResetVal`.

Prescaler:
- A shared counter counts 0 to `TickCycles-1` and then wraps.
- `tick` is asserted for one cycle when the counter equals `TickCycles-1`.
- The counter resets to 0 and free-runs; it is never restarted by input activity.

Per-bit filter:
- Each bit has a counter `cnt` of width `$clog2(StableTicks+1)`. It resets to 0.
- If `sync == sw_o` in a cycle, `cnt` is cleared to 0 in that same cycle, whether or not `tick` is high.
- If `sync != sw_o` and `tick` is high:
  - If `cnt == StableTicks-1`: `sw_o <= sync`, `cnt <= 0`, and the rise/fall pulse fires in the next cycle, which is the cycle `sw_o` changes.
  - Otherwise `cnt <= cnt + 1`.
- If `sync != sw_o` and `tick` is low, `cnt` holds.
- Any return of `sync` to the accepted level, even for one cycle, restarts qualification from zero.
- Bits are fully independent. Several bits may change in the same cycle, each with its own `rise_o`/`fall_o` bit set, and `changed_o` high once.

Edge outputs:
- `rise_o = sw_o & ~sw_q` and `fall_o = ~sw_o & sw_q`, derived from the registered transition. `sw_q` is the previous `sw_o` and resets to `ResetVal`.
- Pulses are exactly one cycle wide.
- An edge never fires out of reset, because `sw_o`, `sw_q` and the synchroniser all start at `ResetVal`.

Reset mid-operation: everything returns immediately to its reset state and all pulses are removed. After release the prescaler starts again from 0.

## Timing
Reset values:
- `sw_o = ResetVal`, `rise_o = 0`, `fall_o = 0`, `changed_o = 0`.

Latency from a clean step on `sw_i` to `sw_o` changing:
- Minimum: 2 + (StableTicks-1)·TickCycles + 1 cycles.
- Maximum: 2 + StableTicks·TickCycles + 1 cycles.
- The range comes from the 2 synchroniser cycles, the phase of `tick` relative to the step, and 1 cycle for the output register.

Pulse timing:
- `rise_o`, `fall_o` and `changed_o` are asserted in the same cycle as the new `sw_o` value.

Glitch rejection:
- Any input change stable for fewer than (StableTicks-1)·TickCycles cycles is never propagated.

No handshake: the outputs are level and pulse signals. The consumer samples them every cycle.

## Structure
- Add `SwDebounceTickCycles` and `SwDebounceStableTicks` defaults to `sonata_pkg`. The top level derives `TickCycles` from `SysClkFreq` (1 ms) and passes it in.
- Use the existing `prim_flop_2sync` for the synchroniser.
- One sub-module, `switch_debounce_bit`: the `cnt` counter, accept logic and edge detect for a single bit. It is instantiated `Width` times by a generate loop.
- The prescaler stays in the parent.

## Test plan
Bench parameters: `TickCycles=4`, `StableTicks=3`, `Width=16`, `ResetVal=0`.
1. **Reset:** hold `rst_sys_ni` low with `sw_i=16'hFFFF`, then release → `sw_o=0` and no pulses during reset. `sw_o` becomes `16'hFFFF` 11–15 cycles after release, with `rise_o=16'hFFFF` and `changed_o=1` for exactly one cycle.
2. **Clean step:** drive `sw_i[3]` 0→1 and hold → `sw_o[3]` rises within 11–15 cycles, `rise_o` = `16'h0008` for one cycle, `fall_o` stays 0.
3. **Glitch rejection:** pulse `sw_i[0]` high for 7 cycles, repeating every 20 cycles → `sw_o[0]` stays 0 and `rise_o` never fires.
4. **Bounce:** toggle `sw_i[5]` every 3 cycles for 30 cycles, then hold at 1 → exactly one `rise_o[5]` pulse, 11–15 cycles after the final hold begins.
5. **Simultaneous events:** from `sw_o=16'h00F0`, apply `sw_i=16'h0F00` at once → `sw_o=16'h0F00`, `rise_o=16'h0F00` and `fall_o=16'h00F0` all in the same single cycle, with `changed_o` high for that one cycle.
6. **Reset mid-qualification:** assert reset asynchronously 8 cycles after a step on `sw_i[1]`, then release → `sw_o=0` immediately, the prescaler restarts from 0, and `sw_o[1]` rises 11–15 cycles after release with no earlier pulse.
